output_drain: RTL
=================

Name: output_drain

Overview:
- Consumer end of the accelerator's result interface.
- Captures each accumulated output pixel announced by the conv controller (valid pulse plus x/y/ch coordinates) into an internal FIFO.
- Transmits results to the host/testbench over a valid/ready stream with a linear output address.
- Counts delivered results, flags overflow, and asserts done once the full feature map has left the block.

Parameters:
FEATURE_MAP_WIDTH, 1024, output map width (x range)
FEATURE_MAP_HEIGHT, 1024, output map height (y range)
OUTPUT_NB_CHANNELS, 64, output channels (ch range)
ACC_WIDTH, 32, width of accumulated result word
FIFO_DEPTH, 8, result buffer entries, power of two, >=4
ADDR_WIDTH, 32, width of linear output address

Ports:
clk  in  1  clock
arst_n_in  in  1  asynchronous reset, active low
start  in  1  one-cycle pulse; clears counters/flags, arms block
in_valid  in  1  result present this cycle (no ready path back; must be accepted)
in_data  in  ACC_WIDTH  accumulated result, signed
in_x  in  32  output x coordinate
in_y  in  32  output y coordinate
in_ch  in  32  output channel
stall_req  out  1  FIFO almost full; controller should stop issuing MACs
out_valid  out  1  result word available to host
out_ready  in  1  host accepts word
out_data  out  ACC_WIDTH  result word
out_addr  out  ADDR_WIDTH  (in_y*FEATURE_MAP_WIDTH + in_x)*OUTPUT_NB_CHANNELS + in_ch, truncated to ADDR_WIDTH
overflow  out  1  sticky: in_valid arrived while FIFO full
done  out  1  all results delivered
delivered_cnt  out  32  results handed to host since start

Behaviour:
- Reset: state IDLE; FIFO empty; out_valid=0, stall_req=0, overflow=0, done=0, delivered_cnt=0; out_data/out_addr=0.
- States: IDLE, COLLECT, DONE.
- IDLE -> COLLECT on start. In IDLE, in_valid is ignored and out_valid stays 0.
- COLLECT -> DONE when delivered_cnt reaches TOTAL=W*H*OUTPUT_NB_CHANNELS on a handshake and the FIFO becomes empty.
- DONE: done=1; returns to COLLECT on start, with counters and overflow cleared.
- start in any state clears the FIFO, counters and overflow, then enters COLLECT. start has priority over a same-cycle in_valid, which is dropped.
- Enqueue: in COLLECT with in_valid and FIFO not full, store {in_data, computed address}.
  - Address is computed combinationally from in_x/in_y/in_ch; multiply widths are 32-bit, truncated to ADDR_WIDTH.
- Overflow: in_valid while FIFO full and no same-cycle dequeue -> word dropped, overflow=1 until start or reset.
  - Full with a simultaneous dequeue is NOT overflow: enqueue and dequeue both occur.
- Dequeue: out_valid = FIFO not empty; head word presented first-word-fall-through.
  - Handshake = out_valid && out_ready; pops the entry and increments delivered_cnt.
  - out_data/out_addr are stable while out_valid && !out_ready.
- Latency: a word enqueued in cycle N is visible on out_valid in cycle N+1 (registered FIFO storage).
- stall_req = occupancy >= FIFO_DEPTH-2. This covers the controller's registered output_valid plus one in-flight pulse.
- Simultaneous enqueue and dequeue: occupancy unchanged; pointers wrap modulo FIFO_DEPTH.
- Async reset mid-operation: discards all contents; no output glitches after deassertion.
- Results arriving after delivered_cnt==TOTAL are accepted and delivered. done stays asserted; delivered_cnt saturates at 2^32-1.

Optional Feature:
- Macro: OUTPUT_DRAIN_RELU_EN.
- Defined: negative in_data (MSB=1) is replaced by 0 before enqueue; address unaffected.
- Undefined: in_data is passed unmodified.
- The clamp is combinational on the enqueue path and adds no latency.

Decomposition:
- Shared package holds:
  - drain_state_t enum (IDLE, COLLECT, DONE).
  - TOTAL_OUTPUTS localparam function of map/channel parameters.
  - The address-compute function, reused by the testbench scoreboard.
- Natural sub-module: sync_fifo, parameterized WIDTH/DEPTH.
  - Ports: push, pop, din, dout, full, empty, count.
  - Drain instantiates it with WIDTH=ACC_WIDTH+ADDR_WIDTH.
- The existing `REG` macro is used for counters and flags.

Test Plan:
- W=2,H=2,CH=2, out_ready=1: start, 8 in_valid pulses with data 1..8 in x,y,ch order -> out_addr 0..7 in order with matching data, done asserts the cycle after the 8th handshake, delivered_cnt=8.
- FIFO_DEPTH=4, out_ready=0: 3 pulses -> stall_req=1 after 2nd enqueue; 4th pulse fills FIFO; 5th pulse -> overflow=1, 5th word lost; release out_ready -> exactly 4 words out.
- FIFO full, out_ready=1 with in_valid same cycle -> no overflow, occupancy stays 4.
- Random out_ready (50%) over 64 results -> stream stable while stalled; scoreboard order, data and address all match.
- in_x=1,in_y=1,in_ch=1, W=2, CH=2 -> out_addr=7; with OUTPUT_DRAIN_RELU_EN, in_data=-5 -> out_data=0, without it -> out_data=-5.
- Reset asserted with 3 queued words -> out_valid=0 and delivered_cnt=0 immediately; after start, new results flow normally.

Source files
------------

// File: rtl/output_drain_pkg.sv
// Shared definitions for the output drain: the register macro used for
// counters and flags, the drain state encoding, the output-count helper and
// the linear address computation (also usable by a testbench scoreboard).

`ifndef REG
// Asynchronously reset register: q takes rst_v while rst_n is low, else d.
`define REG(clk_s, rst_ns, q_s, d_s, rst_v) \
  always_ff @(posedge clk_s or negedge rst_ns) \
    if (!rst_ns) q_s <= (rst_v); \
    else q_s <= (d_s);
`endif

package output_drain_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } drain_state_t;

  localparam int DEF_MAP_WIDTH  = 1024;
  localparam int DEF_MAP_HEIGHT = 1024;
  localparam int DEF_NB_CHANNELS = 64;

  // Number of results making up one complete output feature map.
  function automatic logic [31:0] total_outputs(input int map_w, input int map_h,
                                                input int nb_ch);
    return 32'(map_w * map_h * nb_ch);
  endfunction

  localparam logic [31:0] TOTAL_OUTPUTS =
    total_outputs(DEF_MAP_WIDTH, DEF_MAP_HEIGHT, DEF_NB_CHANNELS);

  // Linear address (y*W + x)*CH + ch with every product kept at 32 bits.
  function automatic logic [31:0] calc_addr(input logic [31:0] x,
                                            input logic [31:0] y,
                                            input logic [31:0] ch,
                                            input logic [31:0] map_w,
                                            input logic [31:0] nb_ch);
    return (y * map_w + x) * nb_ch + ch;
  endfunction

endpackage

// File: rtl/output_drain_sync_fifo.sv
// Synchronous first-word-fall-through FIFO used as the drain result buffer.
// Storage is registered, so a word pushed in cycle N is readable in N+1.
// clr empties the FIFO synchronously; a push and pop on a full FIFO both occur.

module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     arst_n_in,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty && !clr;
  assign do_push = push && !clr && (!full || do_pop);

  // Next pointer and occupancy values; pointers wrap naturally modulo DEPTH.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  // NOTE: sequential state is always assigned with <= so all registers update together.
  `REG(clk, arst_n_in, wr_ptr_q, wr_ptr_d, '0)
  `REG(clk, arst_n_in, rd_ptr_q, rd_ptr_d, '0)
  `REG(clk, arst_n_in, count_q, count_d, '0)

  // Word storage.
  // NOTE: the array has no reset; an empty FIFO never exposes it, so resetting it buys nothing.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/output_drain.sv
// Output drain: consumer end of the accelerator result interface.
// Buffers each announced result with its linear address, streams it to the
// host over valid/ready, counts deliveries, flags overflow and raises done
// once the full feature map has left the block.
// Optional build macro OUTPUT_DRAIN_RELU_EN clamps negative results to zero
// on the enqueue path (address unaffected, no added latency).

module output_drain
  import output_drain_pkg::*;
#(
  parameter int FEATURE_MAP_WIDTH  = DEF_MAP_WIDTH,
  parameter int FEATURE_MAP_HEIGHT = DEF_MAP_HEIGHT,
  parameter int OUTPUT_NB_CHANNELS = DEF_NB_CHANNELS,
  parameter int ACC_WIDTH          = 32,
  parameter int FIFO_DEPTH         = 8,
  parameter int ADDR_WIDTH         = 32
) (
  input  logic                  clk,
  input  logic                  arst_n_in,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [ACC_WIDTH-1:0]  in_data,
  input  logic [31:0]           in_x,
  input  logic [31:0]           in_y,
  input  logic [31:0]           in_ch,
  output logic                  stall_req,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  out_data,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  overflow,
  output logic                  done,
  output logic [31:0]           delivered_cnt
);

  localparam int          WORD_W = ACC_WIDTH + ADDR_WIDTH;
  localparam int          CW     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] TOTAL  =
    total_outputs(FEATURE_MAP_WIDTH, FEATURE_MAP_HEIGHT, OUTPUT_NB_CHANNELS);

  drain_state_t          state_q, state_d;
  logic [31:0]           cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;

  logic                  armed;
  logic                  enq_req;
  logic                  handshake;
  logic [ACC_WIDTH-1:0]  data_clamped;
  logic [ADDR_WIDTH-1:0] enq_addr;
  logic [WORD_W-1:0]     fifo_dout;
  logic                  fifo_full, fifo_empty;
  logic [CW-1:0]         fifo_count;

`ifdef OUTPUT_DRAIN_RELU_EN
  assign data_clamped = in_data[ACC_WIDTH-1] ? '0 : in_data;
`else
  assign data_clamped = in_data;
`endif

  assign enq_addr  = ADDR_WIDTH'(calc_addr(in_x, in_y, in_ch,
                                           32'(FEATURE_MAP_WIDTH),
                                           32'(OUTPUT_NB_CHANNELS)));
  assign armed     = (state_q != IDLE);
  // start wins over a same-cycle result, which is dropped.
  assign enq_req   = armed && in_valid && !start;
  assign out_valid = armed && !fifo_empty;
  assign handshake = out_valid && out_ready;

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .arst_n_in (arst_n_in),
    .clr       (start),
    .push      (enq_req),
    .pop       (handshake),
    .din       ({data_clamped, enq_addr}),
    .dout      (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Head word is forced to zero when nothing is valid so outputs never show stale storage.
  assign out_data      = out_valid ? fifo_dout[WORD_W-1:ADDR_WIDTH] : '0;
  assign out_addr      = out_valid ? fifo_dout[ADDR_WIDTH-1:0] : '0;
  assign stall_req     = (fifo_count >= CW'(FIFO_DEPTH - 2));
  assign overflow      = ovf_q;
  assign done          = (state_q == DONE);
  assign delivered_cnt = cnt_q;

  // Next-state, delivered count and sticky overflow.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (start) begin
      state_d = COLLECT;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      if (handshake && (cnt_q != '1)) cnt_d = cnt_q + 32'd1;
      // Full with a simultaneous pop still accepts the word.
      if (enq_req && fifo_full && !handshake) ovf_d = 1'b1;
      case (state_q)
        IDLE:    state_d = IDLE;
        COLLECT: begin
          if (handshake && (cnt_d >= TOTAL) && (fifo_count == CW'(1)) && !enq_req)
            state_d = DONE;
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Drain state register.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Delivered-result counter and sticky overflow flag.
  `REG(clk, arst_n_in, cnt_q, cnt_d, '0)
  `REG(clk, arst_n_in, ovf_q, ovf_d, 1'b0)

endmodule
